// File: rtl/tl_l1_req_arbiter.sv
// Round-robin arbiter sharing one single-outstanding TileLink adapter port.
// Optional TL_ARB_PRIO0_EN: requester 0 gets strict priority over the rest.
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 2
`endif

module tl_l1_req_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [2*NUM_REQ-1:0] req_type,
  input  logic [`TL_ADDR_BITS*NUM_REQ-1:0] req_address,
  input  logic [`TL_SIZE_BITS*NUM_REQ-1:0] req_size,
  input  logic [`TL_DATA_BYTES*8*NUM_REQ-1:0] req_wdata,
  input  logic [`TL_DATA_BYTES*NUM_REQ-1:0] req_wmask,
  output logic [NUM_REQ-1:0] resp_valid,
  output logic resp_err,
  output logic [`TL_DATA_BYTES*8-1:0] resp_data,
  output logic start_transaction,
  output logic [1:0] transaction_type,
  output logic [`TL_ADDR_BITS-1:0] address,
  output logic [`TL_SIZE_BITS-1:0] size,
  output logic [`TL_SOURCE_BITS-1:0] source,
  output logic [`TL_DATA_BYTES*8-1:0] write_data,
  output logic [`TL_DATA_BYTES-1:0] write_mask,
  input  logic transaction_done,
  input  logic [`TL_DATA_BYTES*8-1:0] read_data
);

  localparam int AW = `TL_ADDR_BITS;
  localparam int SW = `TL_SIZE_BITS;
  localparam int DW = `TL_DATA_BYTES*8;
  localparam int MW = `TL_DATA_BYTES;
  localparam int SRCW = `TL_SOURCE_BITS;
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > (1 << SRCW)) begin : g_bad_cfg
    $error("NUM_REQ out of range for TL_SOURCE_BITS");
  end

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP, REJECT
  } state_t;

  state_t state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] gnt_idx;
  logic gnt_any;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] q_oh;
  logic [1:0] sel_type;
  logic [AW-1:0] sel_addr;
  logic [SW-1:0] sel_size;
  logic [DW-1:0] sel_wdata;
  logic [MW-1:0] sel_wmask;

  // Search starts one past the last winner so it drops to lowest priority.
  always_comb begin
    int idx;
    idx = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
`ifdef TL_ARB_PRIO0_EN
    if (req_valid[0]) begin
      gnt_any = 1'b1;
    end else begin
      for (int k = 1; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr) - 1 + k) % (NUM_REQ - 1) + 1;
        if (!gnt_any && req_valid[IW'(idx)]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'(idx);
        end
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && req_valid[IW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
`endif
    if (state != IDLE || rst) gnt_any = 1'b0;
  end

  assign gnt_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
  assign q_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
  assign req_ready = gnt_any ? gnt_oh : '0;

  always_comb begin
    sel_type = '0;
    sel_addr = '0;
    sel_size = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == gnt_idx) begin
        sel_type = req_type[2*i +: 2];
        sel_addr = req_address[AW*i +: AW];
        sel_size = req_size[SW*i +: SW];
        sel_wdata = req_wdata[DW*i +: DW];
        sel_wmask = req_wmask[MW*i +: MW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      start_transaction <= 1'b0;
      transaction_type <= '0;
      address <= '0;
      size <= '0;
      source <= '0;
      write_data <= '0;
      write_mask <= '0;
      resp_valid <= '0;
      resp_err <= 1'b0;
      resp_data <= '0;
    end else begin
      start_transaction <= 1'b0;
      resp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            grant_q <= gnt_idx;
            transaction_type <= sel_type;
            address <= sel_addr;
            size <= sel_size;
            source <= SRCW'(gnt_idx);
            write_data <= sel_wdata;
            write_mask <= sel_wmask;
`ifdef TL_ARB_PRIO0_EN
            if (gnt_idx != '0) rr_ptr <= gnt_idx;
`else
            rr_ptr <= gnt_idx;
`endif
            if (sel_type == 2'd3) begin
              state <= REJECT;
              resp_valid <= gnt_oh;
              resp_err <= 1'b1;
              resp_data <= '0;
            end else begin
              state <= ISSUE;
              start_transaction <= 1'b1;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (transaction_done) begin
            state <= RESP;
            resp_valid <= q_oh;
            resp_err <= 1'b0;
            resp_data <= read_data;
          end
        end
        RESP, REJECT: begin
          state <= IDLE;
          resp_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_l1_req_arbiter.sv
// Randomised bench for tl_l1_req_arbiter against a queue-free grant model.
// Expected grants come from cyclic distance to the previous winner.
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 2
`endif

module tb_tl_l1_req_arbiter;
  localparam int N = 4;
  localparam int AW = `TL_ADDR_BITS;
  localparam int SW = `TL_SIZE_BITS;
  localparam int DW = `TL_DATA_BYTES*8;
  localparam int MW = `TL_DATA_BYTES;
  localparam int SB = `TL_SOURCE_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid, req_ready, resp_valid;
  logic [2*N-1:0] req_type;
  logic [AW*N-1:0] req_address;
  logic [SW*N-1:0] req_size;
  logic [DW*N-1:0] req_wdata;
  logic [MW*N-1:0] req_wmask;
  logic resp_err, start_transaction, transaction_done;
  logic [DW-1:0] resp_data, write_data, read_data;
  logic [1:0] transaction_type;
  logic [AW-1:0] address;
  logic [SW-1:0] size;
  logic [SB-1:0] source;
  logic [MW-1:0] write_mask;

  logic [N-1:0] vld;
  logic [1:0] typ [N];
  logic [AW-1:0] adr [N];
  logic [SW-1:0] siz [N];
  logic [DW-1:0] wdt [N];
  logic [MW-1:0] wmk [N];

  int checks = 0;
  int errors = 0;
  int rr_m;

  tl_l1_req_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_address(req_address),
    .req_size(req_size), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_data(resp_data),
    .start_transaction(start_transaction),
    .transaction_type(transaction_type),
    .address(address), .size(size), .source(source),
    .write_data(write_data), .write_mask(write_mask),
    .transaction_done(transaction_done),
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = vld;
    req_type = '0;
    req_address = '0;
    req_size = '0;
    req_wdata = '0;
    req_wmask = '0;
    for (int i = 0; i < N; i++) begin
      req_type[2*i +: 2] = typ[i];
      req_address[AW*i +: AW] = adr[i];
      req_size[SW*i +: SW] = siz[i];
      req_wdata[DW*i +: DW] = wdt[i];
      req_wmask[MW*i +: MW] = wmk[i];
    end
  end

  // Winner is the requester at the smallest cyclic distance after rr.
  function automatic int model_grant(logic [N-1:0] v, int rr);
    int best, bd, d;
    best = -1;
    bd = N + 1;
`ifdef TL_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int c = 1; c < N; c++) begin
      if (v[c]) begin
        d = (c - rr + (N - 1)) % (N - 1);
        if (d == 0) d = N - 1;
        if (d < bd) begin bd = d; best = c; end
      end
    end
`else
    for (int c = 0; c < N; c++) begin
      if (v[c]) begin
        d = (c - rr + N) % N;
        if (d == 0) d = N;
        if (d < bd) begin bd = d; best = c; end
      end
    end
`endif
    return best;
  endfunction

  function automatic void model_update(int g);
`ifdef TL_ARB_PRIO0_EN
    if (g != 0) rr_m = g;
`else
    rr_m = g;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    vld = '0;
    for (int i = 0; i < N; i++) begin
      typ[i] = 2'd0;
      adr[i] = '0;
      siz[i] = '0;
      wdt[i] = '0;
      wmk[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    transaction_done = 1'b0;
    read_data = '0;
    rr_m = N - 1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full transaction from the model-predicted grant to its response.
  task automatic serve(input int lat, input bit hold, input bit fix_rd,
                       input logic [DW-1:0] rdv, input bit spur,
                       output int g);
    int eg, l;
    logic [N-1:0] oh;
    logic [1:0] t;
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    logic [DW-1:0] wd, rd;
    logic [MW-1:0] wm;
    eg = model_grant(vld, rr_m);
    g = eg;
    oh = '0;
    if (eg >= 0) oh[eg] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== oh) begin
      errors++;
      $display("FAIL grant ready=%b exp=%b", req_ready, oh);
    end
    if (eg < 0) begin
      tick();
      return;
    end
    t = typ[eg]; a = adr[eg]; s = siz[eg];
    wd = wdt[eg]; wm = wmk[eg];
    model_update(eg);
    tick();
    if (!hold) vld[eg] = 1'b0;
    @(negedge clk);
    if (t == 2'd3) begin
      checks++;
      if ({start_transaction, resp_valid, resp_err, resp_data}
          !== {1'b0, oh, 1'b1, DW'(0)}) begin
        errors++;
        $display("FAIL reject st=%b rv=%b err=%b rd=%h exp rv=%b err=1 rd=0",
                 start_transaction, resp_valid, resp_err, resp_data, oh);
      end
      tick();
      return;
    end
    checks++;
    if ({start_transaction, transaction_type, address, size, source,
         write_data, write_mask} !== {1'b1, t, a, s, SB'(eg), wd, wm}) begin
      errors++;
      $display("FAIL issue st=%b ty=%0d ad=%h sz=%0d src=%0d wd=%h wm=%h exp ty=%0d ad=%h sz=%0d src=%0d wd=%h wm=%h",
               start_transaction, transaction_type, address, size, source,
               write_data, write_mask, t, a, s, eg, wd, wm);
    end
    if (spur) transaction_done = 1'b1;
    l = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
    tick();
    transaction_done = 1'b0;
    for (int k = 0; k < l; k++) begin
      @(negedge clk);
      checks++;
      if ({start_transaction, resp_valid, req_ready} !== '0) begin
        errors++;
        $display("FAIL wait st=%b rv=%b rdy=%b exp all 0",
                 start_transaction, resp_valid, req_ready);
      end
      tick();
    end
    rd = fix_rd ? rdv : DW'($urandom);
    read_data = rd;
    transaction_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({start_transaction, resp_valid} !== '0) begin
      errors++;
      $display("FAIL done_cycle st=%b rv=%b exp 0", start_transaction, resp_valid);
    end
    tick();
    transaction_done = 1'b0;
    read_data = DW'($urandom);
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, resp_data, req_ready}
        !== {oh, 1'b0, rd, N'(0)}) begin
      errors++;
      $display("FAIL resp rv=%b err=%b rd=%h rdy=%b exp rv=%b err=0 rd=%h rdy=0",
               resp_valid, resp_err, resp_data, req_ready, oh, rd);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    vld = '1;
    transaction_done = 1'b0;
    read_data = '0;
    rr_m = N - 1;
    tick();
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, resp_data, start_transaction,
         transaction_type, address, size, source, write_data,
         write_mask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b rv=%b st=%b exp all 0",
               req_ready, resp_valid, start_transaction);
    end
    tick();
    rst = 1'b0;
    vld = '0;
  endtask

  task automatic test_get();
    int g;
    do_reset();
    vld[1] = 1'b1; typ[1] = 2'd0;
    adr[1] = AW'(32'h100); siz[1] = SW'(2);
    serve(2, 1'b0, 1'b1, DW'(32'hDEADBEEF), 1'b0, g);
    checks++;
    if (g != 1) begin
      errors++;
      $display("FAIL get_grant got=%0d exp=1", g);
    end
  endtask

  task automatic test_all_four();
    int g;
    int exp_o [6];
`ifdef TL_ARB_PRIO0_EN
    exp_o = '{0, 0, 0, 0, 0, 0};
`else
    exp_o = '{0, 1, 2, 3, 0, 1};
`endif
    do_reset();
    vld = '1;
    for (int i = 0; i < N; i++) begin
      adr[i] = AW'($urandom);
      wdt[i] = DW'($urandom);
      typ[i] = 2'(i % 2);
    end
    for (int k = 0; k < 6; k++) begin
      serve(-1, 1'b1, 1'b0, '0, 1'b0, g);
      checks++;
      if (g != exp_o[k]) begin
        errors++;
        $display("FAIL all_four_order step=%0d got=%0d exp=%0d", k, g, exp_o[k]);
      end
    end
    vld = '0;
  endtask

  task automatic test_putpartial();
    int g;
    do_reset();
    vld[2] = 1'b1; typ[2] = 2'd2;
    adr[2] = AW'(32'h2040); siz[2] = SW'(1);
    wdt[2] = DW'(32'hA5); wmk[2] = MW'(4'hF);
    serve(1, 1'b0, 1'b0, '0, 1'b0, g);
  endtask

  task automatic test_reject();
    int g;
    do_reset();
    vld[3] = 1'b1; typ[3] = 2'd3;
    adr[3] = AW'(32'h3000);
    serve(0, 1'b0, 1'b0, '0, 1'b0, g);
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, start_transaction} !== '0) begin
      errors++;
      $display("FAIL reject_after rv=%b err=%b st=%b exp 0",
               resp_valid, resp_err, start_transaction);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int g;
    do_reset();
    vld[1] = 1'b1; typ[1] = 2'd0; adr[1] = AW'(32'h500);
    @(negedge clk);
    tick();
    vld = '0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, resp_data, start_transaction,
         transaction_type, address, source} !== '0) begin
      errors++;
      $display("FAIL reset_mid rv=%b st=%b ad=%h exp all 0",
               resp_valid, start_transaction, address);
    end
    transaction_done = 1'b1;
    tick();
    transaction_done = 1'b0;
    tick();
    rst = 1'b0;
    rr_m = N - 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, start_transaction} !== '0) begin
        errors++;
        $display("FAIL stale_resp rv=%b st=%b exp 0", resp_valid, start_transaction);
      end
      tick();
    end
    vld[0] = 1'b1; typ[0] = 2'd0; adr[0] = AW'(32'h40);
    vld[2] = 1'b1; typ[2] = 2'd1; adr[2] = AW'(32'h80);
    serve(-1, 1'b0, 1'b0, '0, 1'b0, g);
    checks++;
    if (g != 0) begin
      errors++;
      $display("FAIL reset_first_grant got=%0d exp=0", g);
    end
    serve(-1, 1'b0, 1'b0, '0, 1'b0, g);
  endtask

  task automatic test_spurious();
    int g;
    do_reset();
    transaction_done = 1'b1;
    @(negedge clk);
    tick();
    transaction_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({resp_valid, start_transaction, req_ready} !== '0) begin
      errors++;
      $display("FAIL spurious_idle rv=%b st=%b exp 0", resp_valid, start_transaction);
    end
    tick();
    vld[1] = 1'b1; typ[1] = 2'd0; adr[1] = AW'(32'h777);
    serve(2, 1'b0, 1'b0, '0, 1'b1, g);
  endtask

  task automatic test_prio_pair();
    int g;
    int exp_o [4];
`ifdef TL_ARB_PRIO0_EN
    exp_o = '{0, 0, 0, 0};
`else
    exp_o = '{0, 3, 0, 3};
`endif
    do_reset();
    vld[0] = 1'b1; vld[3] = 1'b1;
    typ[0] = 2'd0; typ[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      serve(-1, 1'b1, 1'b0, '0, 1'b0, g);
      checks++;
      if (g != exp_o[k]) begin
        errors++;
        $display("FAIL prio_pair step=%0d got=%0d exp=%0d", k, g, exp_o[k]);
      end
    end
    vld = '0;
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 1) == 1) begin
          vld[i] = 1'b1;
          typ[i] = 2'($urandom_range(0, 3));
          adr[i] = AW'($urandom);
          siz[i] = SW'($urandom_range(0, 7));
          wdt[i] = DW'($urandom);
          wmk[i] = MW'($urandom_range(0, 15));
        end
      end
      if ($urandom_range(0, 7) == 0) vld[$urandom_range(0, N-1)] = 1'b0;
      if (vld != '0) begin
        serve(-1, 1'b0, 1'b0, '0, 1'b0, g);
      end else begin
        @(negedge clk);
        checks++;
        if (req_ready !== '0) begin
          errors++;
          $display("FAIL idle_ready rdy=%b exp 0", req_ready);
        end
        tick();
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_get();
    test_all_four();
    test_putpartial();
    test_reject();
    test_reset_mid();
    test_spurious();
    test_prio_pair();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
